// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM word addressing and the IF/ID register.
// Define FETCH_HALT_EN to compile in the HALTED state and halt-word (CBZ XZR,#0) detection.
module if_stage #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          stall_i,
  input  logic          pcsrc_i,
  input  logic [N-1:0]  branch_target_i,
  output logic [N-1:0]  pc_o,
  output logic [N-1:0]  if_id_pc_o,
  output logic [31:0]   if_id_instr_o,
  output logic          if_id_valid_o,
  output logic          halt_o
);

  // state  | meaning
  // RUN    | fetching sequentially, reacting to stall/branch
  // HALTED | halt word captured; PC frozen, IF/ID fed bubbles until a branch
  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [31:0] HALT_WORD = 32'hb400001f;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] id_pc_q, id_pc_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic         id_valid_q, id_valid_d;
  logic [N-1:0] target;
  logic         unused_target_lsbs;

  assign target             = {branch_target_i[N-1:2], 2'b00};
  assign unused_target_lsbs = ^branch_target_i[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_q       <= '0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (pcsrc_i) begin
      // Redirect wins over stall in every state and squashes the wrong-path fetch.
      state_d    = RUN;
      pc_d       = target;
      id_pc_d    = '0;
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else if (!stall_i) begin
      case (state_q)
        RUN: begin
          id_pc_d    = pc_q;
          id_instr_d = imem_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + N'(4);
`ifdef FETCH_HALT_EN
          if (imem_q == HALT_WORD) begin
            pc_d    = pc_q;
            state_d = HALTED;
          end
`endif
        end
        HALTED: begin
          id_pc_d    = '0;
          id_instr_d = '0;
          id_valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign imem_addr     = pc_q[AW+1:2];
  assign pc_o          = pc_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_instr_o = id_instr_q;
  assign if_id_valid_o = id_valid_q;

`ifdef FETCH_HALT_EN
  assign halt_o = (state_q == HALTED);
`else
  assign halt_o = 1'b0;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined LEGv8 core. It holds the program counter, drives the word address of the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register for decode. It reacts to hazard-unit stalls and to taken branches resolved in MEM by redirecting the PC and squashing the wrong-path fetch.

## Interface

Parameters:
- `N`, default 64: PC and branch-target width.
- `AW`, default 6: instruction-ROM word-address width (64 words).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `imem_addr` out AW: ROM word address, equal to `pc_o[AW+1:2]`.
- `imem_q` in 32: ROM instruction word, valid in the same cycle as `imem_addr`.
- `stall_i` in 1: hazard-unit stall; holds the PC and IF/ID.
- `pcsrc_i` in 1: taken branch from MEM.
- `branch_target_i` in N: branch target; bits [1:0] ignored.
- `pc_o` out N: current fetch PC.
- `if_id_pc_o` out N: PC of the instruction held in IF/ID.
- `if_id_instr_o` out 32: instruction held in IF/ID.
- `if_id_valid_o` out 1: IF/ID holds a real instruction (0 = bubble).
- `halt_o` out 1: fetch is halted (see Configuration).

## Operation

- Reset (async, `reset_n`=0):
  - `pc_o`=0
  - `if_id_pc_o`=0
  - `if_id_instr_o`=32'h0
  - `if_id_valid_o`=0
  - `halt_o`=0
  - state RUN
- The PC register is always word-aligned. Loaded targets are `{branch_target_i[N-1:2],2'b00}`.
- Sequential increment is PC+4, modulo 2^N.
- `imem_addr` wraps every 2^(AW+2) bytes, so PC 0x100 fetches word 0.
- Per-edge priority in RUN:
  - `pcsrc_i`=1: PC←target. IF/ID←bubble (`valid`=0, `instr`=0, `pc`=0). This overrides `stall_i`.
  - else `stall_i`=1: PC and IF/ID hold their values.
  - else: IF/ID←{`pc_o`, `imem_q`, valid=1} and PC←PC+4.
- States are RUN and HALTED. HALTED exists only with the macro.
  - RUN→HALTED happens on a normal capture (neither `pcsrc_i` nor `stall_i`) where `imem_q`==32'hb400001f (CBZ XZR,#0). The halt word is captured with valid=1, and the PC does not advance.
  - In HALTED with `pcsrc_i`=0 and `stall_i`=0: the PC holds, IF/ID←bubble, `halt_o`=1.
  - In HALTED with `stall_i`=1 and `pcsrc_i`=0: everything holds.
  - HALTED→RUN happens on `pcsrc_i`=1, which means an older branch redirected fetch. The PC loads the target, IF/ID←bubble, and `halt_o` falls at that edge.
- Reset mid-operation returns to the reset values immediately, regardless of state.

## Timing

- `imem_addr` is purely combinational from the PC register. The ROM is combinational, so there are 0 wait states.
- Fetch-to-IF/ID latency is 1 cycle: an instruction at PC P appears on `if_id_*` after the edge that ends the cycle in which `pc_o`=P.
- Branch penalty: the redirect takes effect at the edge where `pcsrc_i`=1. The first target instruction is valid in IF/ID one edge later.
- `halt_o` is registered. It rises at the same edge that captures the halt word.

## Configuration

- `FETCH_HALT_EN` defined:
  - HALTED state and halt-word detection are compiled in.
  - Fetch stops at 32'hb400001f, and the ROM stops being re-read.
- Not defined:
  - Only RUN exists.
  - The halt word is treated as an ordinary instruction.
  - `halt_o` is tied to 0.

## Test plan

- Reset then release with no stall/branch, ROM words 0..3 = 32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083:
  - `pc_o` steps 0,4,8,12.
  - IF/ID shows (0,32'hf8000001), then (4,32'hf8008002), and so on, with valid=1 from the second edge.
- `stall_i`=1 for 3 cycles at `pc_o`=8: PC stays at 8, and IF/ID holds (4,32'hf8008002) for 3 cycles. Fetch then resumes with (8,32'hf8000203).
- `pcsrc_i`=1 with `branch_target_i`=0x3B at `pc_o`=0x50:
  - The next `pc_o`=0x38, and IF/ID is a bubble (valid=0, instr=0).
  - After one more edge, IF/ID holds (0x38, ROM[14]).
- `pcsrc_i` and `stall_i` both asserted: the branch wins. PC←target and IF/ID←bubble.
- PC=0xFC increments to 0x100, and `imem_addr` wraps to 0.
- With `FETCH_HALT_EN`, ROM[52]=32'hb400001f:
  - After the capture at `pc_o`=0xD0: `halt_o`=1, IF/ID=(0xD0,32'hb400001f), and the PC stays at 0xD0. Subsequent IF/ID values are bubbles.
  - A later `pcsrc_i`=1 with target 0x10: `halt_o`=0 and `pc_o`=0x10.
  - Without the macro, `pc_o` advances to 0xD4.
